// File: rtl/tdnn_pkg.sv
// tdnn_pkg: shared widths, bank select type, switch FSM states and bank base-address helper
package tdnn_pkg;
  localparam int WEIGHT_WIDTH = 16;
  localparam int BANK_DEPTH = 1200;
  localparam int NUM_BANKS = 4;
  localparam int MEM_ADDR_WIDTH = 13;
  typedef logic [1:0] bank_sel_t;
  typedef enum logic [1:0] {SW_IDLE, SW_WAIT, SW_COMMIT} sw_state_t;
  function automatic logic [MEM_ADDR_WIDTH-1:0] bank_base(input bank_sel_t b);
    return MEM_ADDR_WIDTH'(b) * MEM_ADDR_WIDTH'(BANK_DEPTH);
  endfunction
endpackage

// File: rtl/weight_wbuf_fifo.sv
// weight_wbuf_fifo: update write buffer with occupancy, registered ready and per-bank presence flags
module weight_wbuf_fifo
  import tdnn_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int DEPTH = 4,
  parameter int NB = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  bank_sel_t     push_bank,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output bank_sel_t     head_bank,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [LW-1:0] level,
  output logic          ready,
  output logic [NB-1:0] contains
);
  localparam int PW = $clog2(DEPTH);
  bank_sel_t bank_q [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, off;
  logic do_push, do_pop;
  logic [LW-1:0] level_nx;
  assign do_push = push && level != LW'(DEPTH);
  assign do_pop = pop && level != '0;
  assign level_nx = level + LW'(do_push) - LW'(do_pop);
  assign head_bank = bank_q[rd_ptr];
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      ready <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      level <= level_nx;
      ready <= level_nx != LW'(DEPTH);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) begin
      bank_q[wr_ptr] <= push_bank;
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end
  // an entry is live when its distance from the read pointer is below the occupancy
  always_comb begin
    contains = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (LW'(off) < level) contains[bank_q[i]] = 1'b1;
    end
  end
endmodule

// File: rtl/tdnn_weight_arbiter.sv
// tdnn_weight_arbiter: shares the weight SRAM between generator reads and buffered update writes,
// and switches temperature banks only between inferences once the target bank's writes have landed.
module tdnn_weight_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int WEIGHT_WIDTH = tdnn_pkg::WEIGHT_WIDTH,
  parameter int BANK_DEPTH = tdnn_pkg::BANK_DEPTH,
  parameter int NUM_BANKS = tdnn_pkg::NUM_BANKS,
  parameter int MEM_ADDR_WIDTH = tdnn_pkg::MEM_ADDR_WIDTH,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              gen_start,
  input  logic                              gen_busy,
  input  logic [ADDR_WIDTH-1:0]             gen_addr,
  output logic [WEIGHT_WIDTH-1:0]           gen_weight_data,
  output logic [1:0]                        active_bank,
  input  logic [1:0]                        temp_bank_req,
  input  logic                              temp_bank_valid,
  input  logic                              upd_valid,
  output logic                              upd_ready,
  input  logic [1:0]                        upd_bank,
  input  logic [ADDR_WIDTH-1:0]             upd_addr,
  input  logic [WEIGHT_WIDTH-1:0]           upd_data,
  output logic [MEM_ADDR_WIDTH-1:0]         mem_addr,
  output logic                              mem_we,
  output logic [WEIGHT_WIDTH-1:0]           mem_wdata,
  input  logic [WEIGHT_WIDTH-1:0]           mem_rdata,
  output logic                              switch_pending,
  output logic [$clog2(WBUF_DEPTH+1)-1:0]   wbuf_level,
  output logic                              addr_err
);
  import tdnn_pkg::*;
  sw_state_t state, state_nx;
  bank_sel_t pending_bank, eff_bank, head_bank;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [NUM_BANKS-1:0] contains;
  logic gen_own, drain, push_req, in_range, push, commit, can_commit;
  logic [MEM_ADDR_WIDTH-1:0] gen_phys, upd_phys;
  assign gen_own = gen_start | gen_busy;
  assign drain = !gen_own && wbuf_level != '0;
  assign push_req = upd_valid && upd_ready;
  assign in_range = upd_addr < ADDR_WIDTH'(BANK_DEPTH);
  assign push = push_req && in_range;
  assign commit = state == SW_COMMIT;
  // a read issued in the commit cycle already sees the bank being committed
  assign eff_bank = commit ? pending_bank : active_bank;
  assign gen_phys = MEM_ADDR_WIDTH'(bank_base(eff_bank)) + MEM_ADDR_WIDTH'(gen_addr);
  assign upd_phys = MEM_ADDR_WIDTH'(bank_base(head_bank)) + MEM_ADDR_WIDTH'(head_addr);
  assign mem_addr = drain ? upd_phys : gen_phys;
  assign mem_we = drain;
  assign gen_weight_data = mem_rdata;
  weight_wbuf_fifo #(
    .AW(ADDR_WIDTH), .DW(WEIGHT_WIDTH), .DEPTH(WBUF_DEPTH), .NB(NUM_BANKS)
  ) u_wbuf (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_bank(upd_bank),
    .push_addr(upd_addr),
    .push_data(upd_data),
    .pop(drain),
    .head_bank(head_bank),
    .head_addr(head_addr),
    .head_data(mem_wdata),
    .level(wbuf_level),
    .ready(upd_ready),
    .contains(contains)
  );
  // a request arriving this cycle would change the target, so hold off committing
  assign can_commit = switch_pending && !gen_own && !temp_bank_valid && !contains[pending_bank]
                      && !(push && upd_bank == pending_bank);
  always_comb begin
    state_nx = state == SW_IDLE ? (switch_pending ? SW_WAIT : SW_IDLE)
             : state == SW_WAIT ? (!switch_pending ? SW_IDLE : can_commit ? SW_COMMIT : SW_WAIT)
             : SW_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SW_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_bank <= '0;
      pending_bank <= '0;
      switch_pending <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (commit) active_bank <= pending_bank;
      if (temp_bank_valid && temp_bank_req != eff_bank) pending_bank <= temp_bank_req;
      switch_pending <= temp_bank_valid ? temp_bank_req != eff_bank : switch_pending && !commit;
      if (push_req && !in_range) addr_err <= 1'b1;
    end
  end
endmodule

// File: doc/tdnn_weight_arbiter.md
Name: tdnn_weight_arbiter

Overview:
- Owns the single-port weight memory behind tdnn_generator and shares it between two requesters: generator inference reads, and weight-update writes from the adaptation engine.
- Sequences temperature-bank switching so that weight_bank_sel only changes between inferences and only once pending writes to the target bank have landed.
- Sits between tdnn_generator, the temperature monitor and the weight SRAM.

Parameters:
- ADDR_WIDTH, 16, generator/update word address width
- WEIGHT_WIDTH, 16, weight word width (Q1.15)
- BANK_DEPTH, 1200, words per bank (weights plus biases)
- NUM_BANKS, 4, temperature banks (2-bit select)
- MEM_ADDR_WIDTH, 13, physical SRAM address width (covers NUM_BANKS*BANK_DEPTH = 4800)
- WBUF_DEPTH, 4, update write FIFO entries (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- gen_start  in  1  generator in_valid pulse
- gen_busy  in  1  generator busy
- gen_addr  in  ADDR_WIDTH  generator weight_addr
- gen_weight_data  out  WEIGHT_WIDTH  read data to generator
- active_bank  out  2  to generator weight_bank_sel
- temp_bank_req  in  2  requested bank
- temp_bank_valid  in  1  request strobe
- upd_valid  in  1  update write valid
- upd_ready  out  1  update write ready
- upd_bank  in  2  target bank
- upd_addr  in  ADDR_WIDTH  target word
- upd_data  in  WEIGHT_WIDTH  data
- mem_addr  out  MEM_ADDR_WIDTH  SRAM address
- mem_we  out  1  SRAM write enable
- mem_wdata  out  WEIGHT_WIDTH  SRAM write data
- mem_rdata  in  WEIGHT_WIDTH  SRAM read data (1-cycle synchronous read)
- switch_pending  out  1  bank request waiting
- wbuf_level  out  3  FIFO occupancy (0..WBUF_DEPTH)
- addr_err  out  1  sticky: out-of-range update dropped

Behaviour:
- Reset values: active_bank=0; switch_pending=0; FIFO empty; wbuf_level=0; addr_err=0; upd_ready=1; mem_we=0. Reset mid-inference or mid-drain discards FIFO contents and any pending request.
- Port ownership is combinational: gen_own = gen_start | gen_busy.
- When gen_own=1, or when gen_own=0 and the FIFO is empty:
  - mem_addr = active_bank*BANK_DEPTH + gen_addr; mem_we=0.
  - gen_weight_data = mem_rdata (passthrough), so read latency stays 1 cycle.
- Drain: when gen_own=0 and the FIFO is non-empty, pop one entry per cycle.
  - mem_addr = bank*BANK_DEPTH + addr; mem_we=1; mem_wdata = data.
  - If gen_start rises, the drain aborts that same cycle; the head entry is not popped.
- Update handshake: push on upd_valid & upd_ready; upd_ready = (wbuf_level != WBUF_DEPTH), registered from occupancy.
  - Full FIFO: upd_ready=0 and no push, even if a pop occurs that cycle.
  - upd_addr >= BANK_DEPTH: the beat is accepted but discarded, and addr_err is set (sticky until rst).
  - Simultaneous push and pop: level is unchanged.
- Bank request capture: on temp_bank_valid:
  - If temp_bank_req == active_bank and nothing is pending: ignored.
  - Otherwise the pending bank is stored and switch_pending=1. A newer request overwrites an older pending one. A request equal to active_bank cancels the pending one.
- Switch FSM:
  - IDLE -> WAIT on a new pending request.
  - WAIT -> COMMIT when gen_own=0 and no FIFO entry (including one being pushed this cycle) targets the pending bank.
  - COMMIT (1 cycle): active_bank <= pending; switch_pending <= 0; -> IDLE.
  - If gen_start asserts during COMMIT, the commit is still taken. The generator samples the new bank from its first read.
  - A temp_bank_valid arriving in COMMIT is captured as a new pending request after the commit.
- Writes to the active bank are legal. They only land between inferences, so no inference ever sees a mix of old and new weights.
- Address arithmetic: the bank*BANK_DEPTH product is computed in MEM_ADDR_WIDTH bits and is unsigned. gen_addr >= BANK_DEPTH is not checked (generator responsibility).

Decomposition:
- Shared package tdnn_pkg: WEIGHT_WIDTH, BANK_DEPTH, NUM_BANKS, bank_sel_t (2-bit), and the bank base-address constant function.
- One sub-module, weight_wbuf_fifo: synchronous FIFO with {bank, addr, data} entries, level output, and a per-bank "contains" flag vector (NUM_BANKS bits) used by the switch FSM.

Test Plan:
- Reset, then gen_start with gen_addr=5 -> mem_addr=5, mem_we=0, active_bank=0, upd_ready=1, wbuf_level=0.
- Push 4 updates (bank 1, addr 10..13, data 0x1111..0x1114) while gen_busy=1 -> upd_ready=0 after the 4th, mem_we stays 0. gen_busy falls -> 4 consecutive mem_we cycles at mem_addr 1210..1213, then level 0.
- temp_bank_req=1 while gen_busy=1 and FIFO holds a bank-1 entry -> switch_pending=1. The switch commits only after gen_busy=0 and that entry drains; active_bank=1 thereafter, and the next read of gen_addr=0 gives mem_addr=1200.
- Drain of 2 entries interrupted by gen_start on the 2nd cycle -> only 1 write, generator read issued that cycle, remaining entry written after gen_busy falls.
- upd_addr=1200 -> beat accepted, no memory write, addr_err=1 held. Request for bank 2 then bank 0 while active=0 -> pending cancelled, active_bank stays 0.
- Assert rst mid-drain with level 3 and a request pending -> all outputs return to reset values immediately (asynchronous), with no further writes.
